// File: rtl/tm_mem_pkg.sv
// Shared types and constants for the Turing machine memory arbiter.
// Requester indices double as bit positions in the req/gnt/rvalid vectors.
package tm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2
  } arb_state_t;

  localparam int REQ_LOAD  = 0;
  localparam int REQ_EXEC  = 1;
  localparam int REQ_DEBUG = 2;
  localparam int NUM_REQ   = 3;

  // Index 3 is not a requester and decodes to an empty vector.
  function automatic logic [NUM_REQ-1:0] onehot3(input logic [1:0] idx);
    logic [NUM_REQ-1:0] v;
    case (idx)
      2'd0:    v = 3'b001;
      2'd1:    v = 3'b010;
      2'd2:    v = 3'b100;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/tm_mem_arbiter_if.sv
// Requester-side and memory-side signals of the tape/state-table memory arbiter.
// Per-requester fields are packed, requester i at [i*width +: width].
interface tm_mem_arbiter_if
  import tm_mem_pkg::*;
#(
  parameter int dw = 4,
  parameter int aw = 6
);

  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    lock;
  logic [NUM_REQ-1:0]    we;
  logic [NUM_REQ*aw-1:0] addr;
  logic [NUM_REQ*dw-1:0] wdata;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    rvalid;
  logic [dw-1:0]         rdata;
  logic [aw-1:0]         mem_addr;
  logic                  mem_re;
  logic                  mem_we;
  logic [dw-1:0]         mem_wdata;
  logic [dw-1:0]         mem_rdata;

  modport slave (
    input  req, lock, we, addr, wdata, mem_rdata,
    output gnt, rvalid, rdata, mem_addr, mem_re, mem_we, mem_wdata
  );

  modport master (
    output req, lock, we, addr, wdata, mem_rdata,
    input  gnt, rvalid, rdata, mem_addr, mem_re, mem_we, mem_wdata
  );

endinterface

// File: rtl/tm_rr_pick.sv
// Combinational round-robin picker: first candidate searching upward from last+1 mod 3.
// last=3 is not a valid pointer and yields no winner.
module tm_rr_pick
  import tm_mem_pkg::*;
(
  input  logic [NUM_REQ-1:0] cand,
  input  logic [1:0]         last,
  output logic [1:0]         win,
  output logic               vld
);

  always_comb begin
    win = 2'd0;
    vld = 1'b0;
    case (last)
      2'd0: begin
        if (cand[1])      begin win = 2'd1; vld = 1'b1; end
        else if (cand[2]) begin win = 2'd2; vld = 1'b1; end
        else if (cand[0]) begin win = 2'd0; vld = 1'b1; end
      end
      2'd1: begin
        if (cand[2])      begin win = 2'd2; vld = 1'b1; end
        else if (cand[0]) begin win = 2'd0; vld = 1'b1; end
        else if (cand[1]) begin win = 2'd1; vld = 1'b1; end
      end
      2'd2: begin
        if (cand[0])      begin win = 2'd0; vld = 1'b1; end
        else if (cand[1]) begin win = 2'd1; vld = 1'b1; end
        else if (cand[2]) begin win = 2'd2; vld = 1'b1; end
      end
      default: begin
        win = 2'd0;
        vld = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/tm_mem_arbiter.sv
// Round-robin arbiter serialising loader, execution and debug accesses onto one memory port.
// One access per two cycles; a locked access holds the port for its owner for up to HoldMax idle cycles.
module tm_mem_arbiter
  import tm_mem_pkg::*;
#(
  parameter int dw      = 4,
  parameter int w       = 64,
  parameter int aw      = $clog2(w),
  parameter int HoldMax = 4
) (
  input  logic             clock,
  input  logic             Reset_n,
  tm_mem_arbiter_if.slave  bus
);

  localparam int CW = $clog2(HoldMax + 1);

  arb_state_t         state_q, state_d;
  logic [1:0]         win_q, win_d;
  logic [1:0]         last_q, last_d;
  logic               we_l_q, we_l_d;
  logic [aw-1:0]      addr_l_q, addr_l_d;
  logic [dw-1:0]      wdata_l_q, wdata_l_d;
  logic               lock_l_q, lock_l_d;
  logic [NUM_REQ-1:0] mask_q, mask_d;
  logic [CW-1:0]      hcnt_q, hcnt_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;

  logic [NUM_REQ-1:0] cand;
  logic [1:0]         pick_win;
  logic               pick_vld;
  logic               lat_en;
  logic [1:0]         lat_idx;

  assign cand = bus.req & ~mask_q;

  tm_rr_pick u_pick (
    .cand (cand),
    .last (last_q),
    .win  (pick_win),
    .vld  (pick_vld)
  );

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    last_d    = last_q;
    we_l_d    = we_l_q;
    addr_l_d  = addr_l_q;
    wdata_l_d = wdata_l_q;
    lock_l_d  = lock_l_q;
    mask_d    = mask_q;
    hcnt_d    = hcnt_q;
    lat_en    = 1'b0;
    lat_idx   = 2'd0;
    rvalid_d  = (state_q == ACCESS && !we_l_q) ? onehot3(win_q) : '0;

    case (state_q)
      IDLE: begin
        mask_d = '0;
        if (pick_vld) begin
          lat_en  = 1'b1;
          lat_idx = pick_win;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        last_d = win_q;
        if (lock_l_q) begin
          state_d = HOLD;
          hcnt_d  = '0;
        end else begin
          // Masking the winner for one IDLE cycle gives it time to drop req after seeing gnt.
          state_d = IDLE;
          mask_d  = onehot3(win_q);
        end
      end
      HOLD: begin
        if (bus.req[win_q]) begin
          lat_en  = 1'b1;
          lat_idx = win_q;
          state_d = ACCESS;
        end else if (hcnt_q == CW'(HoldMax - 1)) begin
          state_d = IDLE;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (lat_en) begin
      win_d     = lat_idx;
      we_l_d    = bus.we[lat_idx];
      lock_l_d  = bus.lock[lat_idx];
      addr_l_d  = bus.addr[lat_idx*aw +: aw];
      wdata_l_d = bus.wdata[lat_idx*dw +: dw];
    end
  end

  always_ff @(posedge clock) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      win_q     <= 2'd0;
      last_q    <= 2'd2;
      we_l_q    <= 1'b0;
      addr_l_q  <= '0;
      wdata_l_q <= '0;
      lock_l_q  <= 1'b0;
      mask_q    <= '0;
      hcnt_q    <= '0;
      rvalid_q  <= '0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      last_q    <= last_d;
      we_l_q    <= we_l_d;
      addr_l_q  <= addr_l_d;
      wdata_l_q <= wdata_l_d;
      lock_l_q  <= lock_l_d;
      mask_q    <= mask_d;
      hcnt_q    <= hcnt_d;
      rvalid_q  <= rvalid_d;
    end
  end

  // Port drive decodes from state and latched fields only, never from req.
  assign bus.gnt       = (state_q == ACCESS) ? onehot3(win_q) : '0;
  assign bus.mem_addr  = (state_q == ACCESS) ? addr_l_q : '0;
  assign bus.mem_we    = (state_q == ACCESS) && we_l_q;
  assign bus.mem_re    = (state_q == ACCESS) && !we_l_q;
  assign bus.mem_wdata = (state_q == ACCESS) ? wdata_l_q : '0;
  assign bus.rvalid    = rvalid_q;
  assign bus.rdata     = (|rvalid_q) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_tm_mem_arbiter.sv
// Directed bench for tm_mem_arbiter with a behavioural single-port memory.
// Memory word i starts as ~i[3:0]; expected read data below are hand-derived from that.
module tb_tm_mem_arbiter;
  import tm_mem_pkg::*;

  logic clock = 1'b0;
  logic Reset_n = 1'b0;
  logic init_mem = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [3:0] mem [64];

  tm_mem_arbiter_if #(.dw(4), .aw(6)) bus ();

  tm_mem_arbiter #(.dw(4), .w(64), .aw(6), .HoldMax(4)) dut (
    .clock   (clock),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (init_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= ~i[3:0];
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
    if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int i, input bit r, input bit l, input bit wr,
                       input logic [5:0] a, input logic [3:0] d);
    bus.req[i]          = r;
    bus.lock[i]         = l;
    bus.we[i]           = wr;
    bus.addr[i*6 +: 6]  = a;
    bus.wdata[i*4 +: 4] = d;
  endtask

  initial begin
    bus.req   = '0;
    bus.lock  = '0;
    bus.we    = '0;
    bus.addr  = '0;
    bus.wdata = '0;

    // Reset state
    tick();
    init_mem = 1'b0;
    tick();
    check("rst_gnt", 32'(bus.gnt), 32'h0);
    check("rst_rvalid", 32'(bus.rvalid), 32'h0);
    check("rst_mem_re", 32'(bus.mem_re), 32'h0);
    check("rst_mem_we", 32'(bus.mem_we), 32'h0);
    check("rst_rdata", 32'(bus.rdata), 32'h0);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    Reset_n = 1'b1;

    // Three-way tie: round-robin order 0,1,2
    drive(0, 1, 0, 0, 6'd5, 4'h0);
    drive(1, 1, 0, 0, 6'd9, 4'h0);
    drive(2, 1, 0, 0, 6'd13, 4'h0);
    tick();
    check("rr_gnt0", 32'(bus.gnt), 32'h1);
    check("rr_addr0", 32'(bus.mem_addr), 32'd5);
    check("rr_re0", 32'(bus.mem_re), 32'h1);
    drive(0, 0, 0, 0, 6'd5, 4'h0);
    tick();
    check("rr_nognt_a", 32'(bus.gnt), 32'h0);
    check("rr_rvalid0", 32'(bus.rvalid), 32'h1);
    check("rr_rdata0", 32'(bus.rdata), 32'hA);
    tick();
    check("rr_gnt1", 32'(bus.gnt), 32'h2);
    check("rr_addr1", 32'(bus.mem_addr), 32'd9);
    drive(1, 0, 0, 0, 6'd9, 4'h0);
    tick();
    check("rr_rvalid1", 32'(bus.rvalid), 32'h2);
    check("rr_rdata1", 32'(bus.rdata), 32'h6);
    tick();
    check("rr_gnt2", 32'(bus.gnt), 32'h4);
    check("rr_addr2", 32'(bus.mem_addr), 32'd13);
    drive(2, 0, 0, 0, 6'd13, 4'h0);
    tick();
    check("rr_rvalid2", 32'(bus.rvalid), 32'h4);
    check("rr_rdata2", 32'(bus.rdata), 32'h2);

    // Loader writes A to 7, debug reads it back
    drive(0, 1, 0, 1, 6'd7, 4'hA);
    tick();
    check("wr_gnt", 32'(bus.gnt), 32'h1);
    check("wr_we", 32'(bus.mem_we), 32'h1);
    check("wr_re", 32'(bus.mem_re), 32'h0);
    check("wr_addr", 32'(bus.mem_addr), 32'd7);
    check("wr_wdata", 32'(bus.mem_wdata), 32'hA);
    drive(0, 0, 0, 0, 6'd0, 4'h0);
    drive(2, 1, 0, 0, 6'd7, 4'h0);
    tick();
    check("wr_no_rvalid", 32'(bus.rvalid), 32'h0);
    tick();
    check("rb_gnt", 32'(bus.gnt), 32'h4);
    check("rb_addr", 32'(bus.mem_addr), 32'd7);
    drive(2, 0, 0, 0, 6'd7, 4'h0);
    tick();
    check("rb_rvalid", 32'(bus.rvalid), 32'h4);
    check("rb_rdata", 32'(bus.rdata), 32'hA);

    // Locked read-modify-write by execution while loader waits
    drive(1, 1, 1, 0, 6'd12, 4'h0);
    tick();
    check("lk_gnt_rd", 32'(bus.gnt), 32'h2);
    check("lk_addr_rd", 32'(bus.mem_addr), 32'd12);
    drive(1, 1, 0, 1, 6'd12, 4'h5);
    drive(0, 1, 0, 0, 6'd3, 4'h0);
    tick();
    check("lk_hold_state", 32'(dut.state_q), 32'(HOLD));
    check("lk_hold_gnt", 32'(bus.gnt), 32'h0);
    check("lk_rvalid", 32'(bus.rvalid), 32'h2);
    check("lk_rdata", 32'(bus.rdata), 32'h3);
    tick();
    check("lk_gnt_wr", 32'(bus.gnt), 32'h2);
    check("lk_we", 32'(bus.mem_we), 32'h1);
    check("lk_wdata", 32'(bus.mem_wdata), 32'h5);
    drive(1, 0, 0, 0, 6'd0, 4'h0);
    tick();
    check("lk_loader_wait", 32'(bus.gnt), 32'h0);
    check("lk_mem_12", 32'(mem[12]), 32'h5);
    tick();
    check("lk_loader_gnt", 32'(bus.gnt), 32'h1);
    check("lk_loader_addr", 32'(bus.mem_addr), 32'd3);
    drive(0, 0, 0, 0, 6'd0, 4'h0);
    tick();
    check("lk_loader_rdata", 32'(bus.rdata), 32'hC);

    // Lock abandoned: HOLD expires after exactly 4 cycles, debug then granted
    drive(1, 1, 1, 0, 6'd20, 4'h0);
    tick();
    check("hx_gnt", 32'(bus.gnt), 32'h2);
    drive(1, 0, 0, 0, 6'd0, 4'h0);
    drive(2, 1, 0, 0, 6'd30, 4'h0);
    tick();
    check("hx_rdata", 32'(bus.rdata), 32'hB);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("hx_hold%0d", k), 32'(dut.state_q), 32'(HOLD));
      check($sformatf("hx_hold_gnt%0d", k), 32'(bus.gnt), 32'h0);
      if (k < 3) tick();
    end
    tick();
    check("hx_idle", 32'(dut.state_q), 32'(IDLE));
    check("hx_idle_gnt", 32'(bus.gnt), 32'h0);
    tick();
    check("hx_dbg_gnt", 32'(bus.gnt), 32'h4);
    check("hx_dbg_addr", 32'(bus.mem_addr), 32'd30);
    drive(2, 0, 0, 0, 6'd0, 4'h0);
    tick();
    check("hx_dbg_rdata", 32'(bus.rdata), 32'h1);

    // Reset in the middle of a read ACCESS
    drive(1, 1, 0, 0, 6'd40, 4'h0);
    tick();
    check("mr_gnt", 32'(bus.gnt), 32'h2);
    Reset_n = 1'b0;
    drive(1, 0, 0, 0, 6'd0, 4'h0);
    tick();
    check("mr_gnt0", 32'(bus.gnt), 32'h0);
    check("mr_rvalid0", 32'(bus.rvalid), 32'h0);
    check("mr_re0", 32'(bus.mem_re), 32'h0);
    check("mr_rdata0", 32'(bus.rdata), 32'h0);
    check("mr_state", 32'(dut.state_q), 32'(IDLE));
    Reset_n = 1'b1;
    drive(0, 1, 0, 0, 6'd1, 4'h0);
    drive(1, 1, 0, 0, 6'd2, 4'h0);
    tick();
    check("mr_tie_gnt", 32'(bus.gnt), 32'h1);
    drive(0, 0, 0, 0, 6'd0, 4'h0);
    tick();
    check("mr_tie_rdata", 32'(bus.rdata), 32'hE);
    tick();
    check("mr_next_gnt", 32'(bus.gnt), 32'h2);
    drive(1, 0, 0, 0, 6'd0, 4'h0);
    tick();
    check("mr_next_rdata", 32'(bus.rdata), 32'hD);

    // Lone requester holding req: one grant every third cycle
    drive(0, 1, 0, 0, 6'd50, 4'h0);
    for (int k = 0; k < 9; k++) begin
      tick();
      check($sformatf("solo_gnt%0d", k), 32'(bus.gnt), (k % 3 == 0) ? 32'h1 : 32'h0);
    end
    drive(0, 0, 0, 0, 6'd0, 4'h0);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tm_mem_arbiter.md
# tm_mem_arbiter

Arbitrates the Turing machine's single-port tape/state-table memory between three requesters: the input loader, the execution FSM, and a debug peek port. It serialises all accesses onto the one memory port with a round-robin, registered req/gnt handshake. A lock/hold mechanism gives the execution FSM an atomic read-then-rewrite of a tape cell. It sits between the requesters and the `Memory` instance, replacing the ad-hoc `Addr_sel` and `Write_en` muxing.

## Interface
- `dw`, 4, word width
- `w`, 64, number of memory words
- `aw`, `$clog2(w)`, address width
- `HoldMax`, 4, maximum idle cycles in HOLD before the lock is forcibly released
- `clock  in  1  sole clock, rising edge`
- `Reset_n  in  1  reset, synchronous, active-low`
- `req  in  3  access request per requester: [0] loader, [1] execution, [2] debug`
- `lock  in  3  per requester; sampled with req; requests HOLD after the access`
- `we  in  3  per requester; 1 = write, 0 = read`
- `addr  in  3×aw  per-requester address, packed [i*aw +: aw]`
- `wdata  in  3×dw  per-requester write data, packed`
- `gnt  out  3  one-hot; high in the ACCESS cycle of the winner`
- `rvalid  out  3  one-hot; high the cycle after a read ACCESS`
- `rdata  out  dw  read data, valid with any rvalid bit`
- `mem_addr  out  aw  memory address`
- `mem_re  out  1  memory read enable`
- `mem_we  out  1  memory write enable`
- `mem_wdata  out  dw  memory write data`
- `mem_rdata  in  dw  memory read data, valid the cycle after mem_re`

## Operation
- States: IDLE, ACCESS, HOLD. Registers: `win` (2b), `last` (2b round-robin pointer), latched `we_l`, `addr_l`, `wdata_l`, `lock_l`, `mask` (3b), hold counter (`$clog2(HoldMax+1)` bits).
- IDLE: candidates = req & ~mask. If nonzero, pick the first candidate searching from `last+1` mod 3, latch its we/addr/wdata/lock into `*_l`, set `win`, go to ACCESS. `mask` clears at the end of every IDLE cycle.
- ACCESS:
  - `gnt[win]`=1, `mem_addr`=`addr_l`, `mem_we`=`we_l`, `mem_re`=~`we_l`, `mem_wdata`=`wdata_l`; `last`←`win`.
  - If `lock_l`, go to HOLD with the hold counter cleared.
  - Otherwise go to IDLE with `mask`=one-hot(`win`). The masked requester sees `gnt` one cycle late and needs that cycle to drop `req`.
- HOLD: only `win` is considered.
  - If `req[win]`, latch its fields and go to ACCESS. That access again obeys `lock`.
  - Else if the counter = `HoldMax`-1, go to IDLE (no mask); otherwise increment the counter.
  - Other requesters wait.
- rvalid: registered. `rvalid[win]` ← (state==ACCESS & ~`we_l`); `rdata` = `mem_rdata` passed through in that cycle, 0 otherwise.
- Out-of-range index 3 never occurs; the picker's default yields no grant.

## Timing
- Reset (Reset_n low at an edge): state IDLE, `last`=2 (so requester 0 wins first), `mask`=0, all `*_l`=0. Every output is 0 in the cycle after that edge, including mid-ACCESS and mid-HOLD; a pending read produces no rvalid.
- All outputs decode from registers only; none is combinational from req.
- Latency: req high in IDLE at cycle N → gnt at N+1 → rvalid at N+2 for reads. Writes take effect at the N+1 edge.
- Throughput: unlocked, at most one access per 2 cycles. Locked, back-to-back ACCESS/HOLD pairs give one access per 2 cycles to the holder.
- Requester rule: keep req/we/addr/wdata stable until gnt is seen, and drop req the cycle after gnt unless another access is wanted. A req dropped before gnt is a protocol violation; behaviour is undefined.
- Simultaneous requests resolve by round-robin only; no requester has fixed priority.

## Structure
- Package `tm_mem_pkg`: the state enum `arb_state_t {IDLE, ACCESS, HOLD}`, requester index constants `REQ_LOAD=0`, `REQ_EXEC=1`, `REQ_DEBUG=2`, and `NUM_REQ=3`.
- Sub-module `tm_rr_pick`: combinational; inputs a 3-bit candidate vector and the 2-bit `last`; outputs the winner index and a valid bit. Instantiated once.

## Test plan
- After reset, req=3'b111, all reads, distinct addrs 5/9/13 → gnt order 001, 010, 100; rvalid one cycle after each gnt with the matching mem_rdata.
- Loader writes wdata=4'hA to addr 7, then debug reads addr 7 → mem_we=1 with addr 7 at gnt; debug rvalid shows rdata=4'hA.
- Execution reads addr 12 with lock=1, then within 2 cycles writes addr 12 with lock=0 while loader holds req → loader is not granted until after the write's ACCESS.
- Execution locks, then holds req low; HoldMax=4 → return to IDLE exactly 4 HOLD cycles later, and the waiting debug req is granted next.
- Reset_n low during ACCESS of a read → the next cycle has gnt=0, rvalid=0, mem_re=0, state IDLE, and requester 0 wins the next tie.
- A single requester holds req high continuously (unlocked) → granted every 3rd cycle (ACCESS, masked IDLE, IDLE), never two consecutive gnt.
